// File: rtl/lane_credit_sched.sv
// rtl/lane_credit_sched.sv - round-robin one-hot lane grants gated by per-lane credits
// Optional STALL-cycle counter port stall_cnt under LANE_CREDIT_SCHED_STALL_CNT_EN.
module lane_credit_sched #(
  parameter int X    = 4,
  parameter int Y    = 1,
  parameter int CRED = 3
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         req_vld,
  input  logic [X-1:0] req_lanes,
  output logic         req_rdy,
  input  logic [X-1:0] rtn,
  output logic [X-1:0] xb,
  output logic [X-1:0] cb,
  output logic         busy,
`ifdef LANE_CREDIT_SCHED_STALL_CNT_EN
  output logic [15:0]  stall_cnt,
`endif
  output logic         cred_err
);

  localparam int CW = $clog2(CRED + 1);
  localparam int PW = (X > 1) ? $clog2(X) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CRED);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  generate
    if (Y != 1) begin : g_y_check
      $error("lane_credit_sched: only Y=1 is supported");
    end
    if (CRED < 1 || CRED > 15) begin : g_cred_check
      $error("lane_credit_sched: CRED must be 1..15");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [X-1:0]  pend_q, pend_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [CW-1:0] cred_q [X];
  logic [CW-1:0] cred_d [X];
  logic [X-1:0]  xb_q, xb_d;
  logic [X-1:0]  cb_q, cb_d;
  logic          err_q, err_d;

  logic [X-1:0]  elig;
  logic [X-1:0]  grant;
  logic          found;
  logic [PW-1:0] sel;
  logic [PW-1:0] idx;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    rr_d    = rr_q;
    err_d   = err_q;
    elig    = '0;
    grant   = '0;
    found   = 1'b0;
    sel     = '0;
    idx     = '0;

    // Eligibility uses the credits held before this cycle's grant/return updates.
    for (int i = 0; i < X; i++) begin
      elig[i] = pend_q[i] && (cred_q[i] != '0);
    end
    for (int i = 0; i < X; i++) begin
      idx = PW'((int'(rr_q) + i) % X);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (req_vld) begin
          pend_d = req_lanes;
          if (req_lanes != '0) state_d = ST_ARB;
        end
      end
      ST_ARB, ST_STALL: begin
        if (found) begin
          grant[sel]  = 1'b1;
          pend_d[sel] = 1'b0;
          rr_d        = PW'((int'(sel) + 1) % X);
          state_d     = (pend_d == '0) ? ST_IDLE : ST_ARB;
        end else begin
          state_d = ST_STALL;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    xb_d = grant;

    for (int i = 0; i < X; i++) begin
      cred_d[i] = cred_q[i];
      if (rtn[i] && !grant[i] && cred_q[i] == CMAX) begin
        err_d = 1'b1;
      end else begin
        cred_d[i] = cred_q[i] - CW'(grant[i]) + CW'(rtn[i]);
      end
      cb_d[i] = (cred_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      rr_q    <= '0;
      xb_q    <= '0;
      cb_q    <= '1;
      err_q   <= 1'b0;
      for (int i = 0; i < X; i++) cred_q[i] <= CMAX;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      xb_q    <= xb_d;
      cb_q    <= cb_d;
      err_q   <= err_d;
      for (int i = 0; i < X; i++) cred_q[i] <= cred_d[i];
    end
  end

`ifdef LANE_CREDIT_SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_STALL && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rstb) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  assign req_rdy  = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign xb       = xb_q;
  assign cb       = cb_q;
  assign cred_err = err_q;

endmodule

// File: tb/tb_lane_credit_sched.sv
// tb/tb_lane_credit_sched.sv - scoreboard bench for lane_credit_sched (X=4, CRED=3)
module tb_lane_credit_sched;

  localparam int X    = 4;
  localparam int CRED = 3;

  logic         clk = 1'b0;
  logic         rstb;
  logic         req_vld;
  logic [X-1:0] req_lanes;
  logic         req_rdy;
  logic [X-1:0] rtn;
  logic [X-1:0] xb;
  logic [X-1:0] cb;
  logic         busy;
  logic         cred_err;
`ifdef LANE_CREDIT_SCHED_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  lane_credit_sched #(.X(X), .Y(1), .CRED(CRED)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .req_vld   (req_vld),
    .req_lanes (req_lanes),
    .req_rdy   (req_rdy),
    .rtn       (rtn),
    .xb        (xb),
    .cb        (cb),
    .busy      (busy),
`ifdef LANE_CREDIT_SCHED_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .cred_err  (cred_err)
  );

  always #5 clk = ~clk;

  int           n_total = 0;
  int           n_bad   = 0;
  logic [X-1:0] exp_q[$];
  int           mcred[X];
  int           mrr;
  bit           mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: round-robin over lanes that hold credit; if none do, the
  // bench is about to return credit, so fall back to the next pending lane.
  task automatic push_grants(input logic [X-1:0] lanes);
    logic [X-1:0] pend;
    int sel, idx;
    pend = lanes;
    while (pend != '0) begin
      sel = -1;
      for (int i = 0; i < X; i++) begin
        idx = (mrr + i) % X;
        if (sel < 0 && pend[idx] && mcred[idx] > 0) sel = idx;
      end
      for (int i = 0; i < X; i++) begin
        idx = (mrr + i) % X;
        if (sel < 0 && pend[idx]) sel = idx;
      end
      exp_q.push_back(X'(1) << sel);
      pend[sel] = 1'b0;
      mcred[sel]--;
      mrr = (sel + 1) % X;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < X; i++) mcred[i] = CRED;
    mrr = 0;
  endtask

  task automatic send(input logic [X-1:0] lanes);
    int n;
    n = 0;
    while (!req_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_rdy) chk("rdy_timeout", 32'(req_rdy), 32'd1);
    req_vld   = 1'b1;
    req_lanes = lanes;
    push_grants(lanes);
    @(posedge clk); #1;
    req_vld   = 1'b0;
    req_lanes = '0;
  endtask

  task automatic ret(input logic [X-1:0] mask);
    rtn = mask;
    @(posedge clk); #1;
    rtn = '0;
    for (int i = 0; i < X; i++) begin
      if (mask[i] && mcred[i] < CRED) mcred[i]++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_rdy && n < 50);
    if (!req_rdy) chk("idle_timeout", 32'(req_rdy), 32'd1);
  endtask

  always @(negedge clk) begin
    if (mon_en && xb != '0) begin
      if (exp_q.size() == 0) chk("xb_extra", 32'(xb), 32'd0);
      else                   chk("grant", 32'(xb), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstb = 1'b1; req_vld = 1'b0; req_lanes = '0; rtn = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstb = 1'b0;
    @(negedge clk);
    chk("rst_xb", 32'(xb), 32'h0);
    chk("rst_cb", 32'(cb), 32'hF);
    chk("rst_rdy", 32'(req_rdy), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(cred_err), 32'd0);
    mon_en = 1'b1;

    send(4'b1011);
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("rdy_after_accept", 32'(req_rdy), 32'd0);
    chk("no_grant_at_e0", 32'(xb), 32'h0);
    wait_idle(n);
    chk("lat_1011", 32'(n), 32'd3);

    send(4'b1111);
    wait_idle(n);
    chk("lat_1111", 32'(n), 32'd5);
    chk("cb_after_1111", 32'(cb), 32'hF);

    ret(4'b1111);
    ret(4'b1011);
    send(4'b0100);
    ret(4'b0100);
    wait_idle(n);
    @(negedge clk);
    chk("simul_err", 32'(cred_err), 32'd0);
    chk("simul_cb", 32'(cb), 32'hF);

    ret(4'b0100);
    @(negedge clk);
    chk("over_err", 32'(cred_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("over_err_sticky", 32'(cred_err), 32'd1);

    repeat (3) begin
      send(4'b0001);
      wait_idle(n);
    end
    @(negedge clk);
    chk("cb_exhausted", 32'(cb), 32'hE);

    send(4'b0001);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_rdy", 32'(req_rdy), 32'd0);
    chk("stall_xb", 32'(xb), 32'h0);
    chk("stall_cb", 32'(cb), 32'hE);
`ifdef LANE_CREDIT_SCHED_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd3);
`endif
    ret(4'b0001);
    @(negedge clk);
    chk("stall_no_early", 32'(xb), 32'h0);
    @(negedge clk);
    chk("stall_grant", 32'(xb), 32'h1);
    wait_idle(n);
    chk("cb_after_stall", 32'(cb), 32'hE);

    send(4'b1111);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;
    rstb = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_rst_xb", 32'(xb), 32'h0);
    chk("mid_rst_rdy", 32'(req_rdy), 32'd1);
    chk("mid_rst_cb", 32'(cb), 32'hF);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(cred_err), 32'd0);
    repeat (6) @(negedge clk);

    send(4'b1001);
    wait_idle(n);
    chk("lat_1001", 32'(n), 32'd3);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
